// File: rtl/serial_inst_mem_responder.sv
// serial_inst_mem_responder
// Memory side of the bit-serial instruction fetch link. Deserialises an
// LSB-first address, reads a word from an internal loadable store and streams
// it back LSB first, one bit per cycle, starting the cycle after the last
// address bit.
// Build option: define SERIAL_MEM_PARITY_EN to append an even-parity bit
// after the last data bit (send becomes DATA_WIDTH+1 cycles).
//
// state     | meaning
// IDLE      | waiting for the first address bit
// RECV_ADDR | shifting in address bits 1..ADDR_WIDTH-1
// SEND_DATA | streaming the latched word (and parity bit when enabled)
module serial_inst_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  addr_valid,
    input  logic                  addr_in,
    output logic                  data_out,
    output logic                  rsp_active,
    output logic                  abort_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH + 1) ? ADDR_WIDTH : DATA_WIDTH + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AW1     = ADDR_WIDTH - 1;
`ifdef SERIAL_MEM_PARITY_EN
    localparam int SEND_LEN = DATA_WIDTH + 1;
`else
    localparam int SEND_LEN = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] SEND_END  = CNT_W'(SEND_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECV_ADDR = 2'd1,
        SEND_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [AW1-1:0]        r_addr;      // first ADDR_WIDTH-1 address bits, bit 0 lands at LSB
    logic [DATA_WIDTH-1:0] r_tx;        // remaining word bits; r_tx[0] is the next to send
    logic                  r_data_out;
    logic                  r_rsp_active;
    logic                  r_abort_err;
    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [AW1-1:0]        w_addr_next;
    logic [DATA_WIDTH-1:0] w_tx_next;
    logic                  w_data_next;
    logic                  w_rsp_next;
    logic                  w_abort_next;
    logic [ADDR_WIDTH-1:0] w_full_addr;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [AW1-1:0]        w_addr_shift;

`ifdef SERIAL_MEM_PARITY_EN
    logic r_parity;
    logic w_parity_next;
`endif

    // The final address bit is used straight from the pin so the read happens
    // on the same edge it arrives; the read sees the pre-write store contents.
    assign w_full_addr  = {addr_in, r_addr};
    assign w_rd_word    = r_mem[w_full_addr];
    assign w_addr_shift = AW1'({addr_in, r_addr} >> 1);

    // Store write port; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_tx         <= '0;
            r_data_out   <= 1'b0;
            r_rsp_active <= 1'b0;
            r_abort_err  <= 1'b0;
`ifdef SERIAL_MEM_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_addr       <= w_addr_next;
            r_tx         <= w_tx_next;
            r_data_out   <= w_data_next;
            r_rsp_active <= w_rsp_next;
            r_abort_err  <= w_abort_next;
`ifdef SERIAL_MEM_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_addr_next   = r_addr;
        w_tx_next     = r_tx;
        w_data_next   = 1'b0;
        w_rsp_next    = 1'b0;
        w_abort_next  = 1'b0;
`ifdef SERIAL_MEM_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (addr_valid) begin
                    w_addr_next  = w_addr_shift;
                    w_cnt_next   = CNT_ONE;
                    w_state_next = RECV_ADDR;
                end
            end
            RECV_ADDR: begin
                if (!addr_valid) begin
                    w_abort_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else if (r_cnt == ADDR_LAST) begin
                    w_data_next  = w_rd_word[0];
                    w_tx_next    = DATA_WIDTH'(w_rd_word >> 1);
                    w_rsp_next   = 1'b1;
                    w_cnt_next   = CNT_ONE;
                    w_state_next = SEND_DATA;
`ifdef SERIAL_MEM_PARITY_EN
                    w_parity_next = ^w_rd_word;
`endif
                end else begin
                    w_addr_next = w_addr_shift;
                    w_cnt_next  = r_cnt + CNT_ONE;
                end
            end
            SEND_DATA: begin
                if (r_cnt == SEND_END) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else begin
                    w_data_next = r_tx[0];
                    w_tx_next   = r_tx >> 1;
                    w_rsp_next  = 1'b1;
                    w_cnt_next  = r_cnt + CNT_ONE;
`ifdef SERIAL_MEM_PARITY_EN
                    if (r_cnt == CNT_W'(DATA_WIDTH)) begin
                        w_data_next = r_parity;
                    end
`endif
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign data_out   = r_data_out;
    assign rsp_active = r_rsp_active;
    assign abort_err  = r_abort_err;

endmodule
